fwd_scoreboard: RTL and testbench

FWD_SCOREBOARD -- requirements
Module: fwd_scoreboard

---
 rtl/fwd_scoreboard_pkg.sv | 23 ++
 rtl/fwd_scoreboard_if.sv | 36 +++
 rtl/fwd_scoreboard_mux.sv | 24 ++
 rtl/fwd_scoreboard.sv | 105 ++++++++++
 tb/tb_fwd_scoreboard.sv | 309 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/fwd_scoreboard_pkg.sv
// Shared types for the operand forwarding scoreboard.
// Register address, data word and forwarding-source bundle.
package fwd_scoreboard_pkg;

   localparam int NREG = 32;
   localparam int AW   = $clog2(NREG);

   typedef logic [AW-1:0] creg_addr_t;
   typedef logic [31:0]   word_t;

   typedef struct packed {
      creg_addr_t dst;
      word_t      data;
      logic       ismem;
   } tran_t;

   // One-hot mask selecting a single register.
   function automatic logic [NREG-1:0] reg_bit(creg_addr_t a);
      reg_bit    = '0;
      reg_bit[a] = 1'b1;
   endfunction

endpackage

// File: rtl/fwd_scoreboard_if.sv
// Decode-side bus of the forwarding scoreboard.
// master drives reads/issue/writeback, slave answers.
interface fwd_scoreboard_if
   import fwd_scoreboard_pkg::*;
#(
   parameter int NREAD = 2,
   parameter int NFWD  = 3
);

   creg_addr_t [NREAD-1:0] ra;
   word_t      [NREAD-1:0] rd;
   tran_t      [NFWD-1:0]  fwd;
   logic                   issue_valid;
   logic                   issue_long;
   creg_addr_t             issue_dst;
   logic                   wb_long_valid;
   creg_addr_t             wb_long_dst;
   word_t      [NREAD-1:0] result;
   logic                   stall;
   logic       [NREG-1:0]  pending;

   modport master (
      output ra, rd, fwd,
      output issue_valid, issue_long, issue_dst,
      output wb_long_valid, wb_long_dst,
      input  result, stall, pending
   );

   modport slave (
      input  ra, rd, fwd,
      input  issue_valid, issue_long, issue_dst,
      input  wb_long_valid, wb_long_dst,
      output result, stall, pending
   );

endinterface

// File: rtl/fwd_scoreboard_mux.sv
// Per-read-port forwarding priority mux.
// Youngest matching source (lowest index) wins; r0 never forwards.
module fwd_mux
   import fwd_scoreboard_pkg::*;
#(
   parameter int NFWD = 3
) (
   input  creg_addr_t            ra,
   input  word_t                 rd,
   input  tran_t     [NFWD-1:0]  fwd,
   output word_t                 result
);

   // Scan oldest to youngest so the youngest match is assigned last.
   always_comb begin
      result = rd;
      if (ra != '0) begin
         for (int j = NFWD - 1; j >= 0; j--) begin
            if (fwd[j].dst == ra) result = fwd[j].data;
         end
      end
   end

endmodule

// File: rtl/fwd_scoreboard.sv
// Operand forwarding and long-latency scoreboard for decode.
// Optional macro FWD_STALL_CNT_EN adds a 64-bit stall cycle counter.
module fwd_scoreboard
   import fwd_scoreboard_pkg::*;
#(
   parameter int NREAD   = 2,
   parameter int NFWD    = 3,
   parameter int MAXLONG = 2
) (
   input  logic clk,
   input  logic reset,
   fwd_scoreboard_if.slave bus
`ifdef FWD_STALL_CNT_EN
   ,
   output logic [63:0] stall_cnt
`endif
);

   localparam int CW = $clog2(MAXLONG + 1);

   logic [NREG-1:0] pend;
   logic [CW-1:0]   count;
   word_t [NREAD-1:0] res;

   logic load_use;
   logic pend_hit;
   logic struct_full;
   logic waw;
   logic stall;
   logic acc_long;
   logic do_clr;
   logic [NREG-1:0] set_m;
   logic [NREG-1:0] clr_m;

   for (genvar i = 0; i < NREAD; i++) begin : g_mux
      fwd_mux #(
         .NFWD(NFWD)
      ) u_mux (
         .ra    (bus.ra[i]),
         .rd    (bus.rd[i]),
         .fwd   (bus.fwd),
         .result(res[i])
      );
   end

   assign bus.result  = res;
   assign bus.pending = pend;
   assign bus.stall   = stall;

   // Hazard detection: load-use, pending long op, full long queue, WAW.
   always_comb begin
      load_use = 1'b0;
      pend_hit = 1'b0;
      for (int i = 0; i < NREAD; i++) begin
         if (bus.ra[i] != '0) begin
            if (bus.fwd[0].ismem && bus.fwd[0].dst == bus.ra[i])
               load_use = 1'b1;
            if (pend[bus.ra[i]] &&
                !(bus.wb_long_valid && bus.wb_long_dst == bus.ra[i]))
               pend_hit = 1'b1;
         end
      end
      struct_full = bus.issue_valid & bus.issue_long &
                    (count == CW'(MAXLONG)) & ~bus.wb_long_valid;
      waw = bus.issue_valid & (bus.issue_dst != '0) &
            pend[bus.issue_dst];
      stall = load_use | pend_hit | struct_full | waw;
   end

   // Set/clear masks for the pending vector; stale writebacks are dropped.
   always_comb begin
      acc_long = bus.issue_valid & ~stall & bus.issue_long &
                 (bus.issue_dst != '0);
      do_clr   = bus.wb_long_valid & (count != '0) &
                 pend[bus.wb_long_dst];
      set_m    = acc_long ? reg_bit(bus.issue_dst) : '0;
      clr_m    = do_clr ? reg_bit(bus.wb_long_dst) : '0;
   end

   // Scoreboard state: set beats clear, count saturates both ways.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pend  <= '0;
         count <= '0;
      end else begin
         pend <= ((pend & ~clr_m) | set_m) & ~NREG'(1);
         unique case (1'b1)
            acc_long & ~do_clr: begin
               if (count != CW'(MAXLONG)) count <= count + 1'b1;
            end
            do_clr & ~acc_long: count <= count - 1'b1;
            default:            count <= count;
         endcase
      end
   end

`ifdef FWD_STALL_CNT_EN
   // Free-running count of stalled cycles, wraps at 2^64.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) stall_cnt <= '0;
      else if (stall) stall_cnt <= stall_cnt + 64'd1;
   end
`endif

endmodule

// File: tb/tb_fwd_scoreboard.sv
// Directed bench for fwd_scoreboard with a per-cycle reference model.
// Define FWD_STALL_CNT_EN to also check the stall counter.
module tb_fwd_scoreboard;
   import fwd_scoreboard_pkg::*;

   localparam int NR = 2;
   localparam int NF = 3;
   localparam int ML = 2;

   logic clk = 1'b0;
   logic reset;

   fwd_scoreboard_if #(.NREAD(NR), .NFWD(NF)) bus ();

`ifdef FWD_STALL_CNT_EN
   logic [63:0] stall_cnt;
`endif

   fwd_scoreboard #(
      .NREAD  (NR),
      .NFWD   (NF),
      .MAXLONG(ML)
   ) dut (
      .clk  (clk),
      .reset(reset),
      .bus  (bus.slave)
`ifdef FWD_STALL_CNT_EN
      ,
      .stall_cnt(stall_cnt)
`endif
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   bit mp [NREG];
   int mc;
   longint unsigned msc;

   task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s got=%0h want=%0h t=%0t", nm, act, exp, $time);
      end
   endtask

   function automatic tran_t mk(int d, int v, bit m);
      tran_t t;
      t.dst   = creg_addr_t'(d);
      t.data  = word_t'(v);
      t.ismem = m;
      return t;
   endfunction

   task automatic idle();
      for (int i = 0; i < NR; i++) begin
         bus.ra[i] = '0;
         bus.rd[i] = '0;
      end
      for (int j = 0; j < NF; j++) bus.fwd[j] = mk(0, 0, 1'b0);
      bus.issue_valid   = 1'b0;
      bus.issue_long    = 1'b0;
      bus.issue_dst     = '0;
      bus.wb_long_valid = 1'b0;
      bus.wb_long_dst   = '0;
   endtask

   task automatic issue(bit lng, int d);
      bus.issue_valid = 1'b1;
      bus.issue_long  = lng;
      bus.issue_dst   = creg_addr_t'(d);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Reference model: checks every cycle at the falling edge.
   initial begin
      bit np [NREG];
      int nc;
      longint unsigned nsc;
      forever begin
         @(negedge clk);
         if (reset) begin
            foreach (mp[k]) mp[k] = 1'b0;
            mc  = 0;
            msc = 0;
         end
         begin
            bit es;
            logic [NREG-1:0] pv;
            bit acc, clr;
            int a, id, wd;
            es = 1'b0;
            for (int i = 0; i < NR; i++) begin
               word_t er;
               bit found;
               a = int'(bus.ra[i]);
               er = bus.rd[i];
               found = 1'b0;
               if (a != 0) begin
                  for (int j = 0; j < NF; j++) begin
                     if (!found && int'(bus.fwd[j].dst) == a) begin
                        er = bus.fwd[j].data;
                        found = 1'b1;
                     end
                  end
                  if (bus.fwd[0].ismem && int'(bus.fwd[0].dst) == a)
                     es = 1'b1;
                  if (mp[a] && !(bus.wb_long_valid &&
                                 int'(bus.wb_long_dst) == a))
                     es = 1'b1;
               end
               chk($sformatf("result%0d", i), 64'(bus.result[i]), 64'(er));
            end
            id = int'(bus.issue_dst);
            wd = int'(bus.wb_long_dst);
            if (bus.issue_valid && bus.issue_long && mc == ML &&
                !bus.wb_long_valid) es = 1'b1;
            if (bus.issue_valid && id != 0 && mp[id]) es = 1'b1;
            chk("stall", 64'(bus.stall), 64'(es));
            for (int k = 0; k < NREG; k++) pv[k] = mp[k];
            chk("pending", 64'(bus.pending), 64'(pv));
`ifdef FWD_STALL_CNT_EN
            chk("stall_cnt", stall_cnt, msc);
`endif
            np  = mp;
            nc  = mc;
            nsc = msc + (es ? 1 : 0);
            acc = bus.issue_valid && !es && bus.issue_long && id != 0;
            clr = bus.wb_long_valid && mc > 0 && mp[wd];
            if (clr) np[wd] = 1'b0;
            if (acc) np[id] = 1'b1;
            if (acc && !clr && nc < ML) nc++;
            if (clr && !acc) nc--;
         end
         @(posedge clk);
         if (reset) begin
            foreach (mp[k]) mp[k] = 1'b0;
            mc  = 0;
            msc = 0;
         end else begin
            mp  = np;
            mc  = nc;
            msc = nsc;
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog t=%0t", $time);
      $fatal(1, "timeout");
   end

   initial begin
      reset = 1'b1;
      idle();
      step();
      step();
      chk("rst_stall", 64'(bus.stall), 64'd0);
      chk("rst_pend", 64'(bus.pending), 64'd0);
      reset = 1'b0;

      // youngest source wins
      step(); idle();
      bus.ra[0]  = 5;
      bus.rd[0]  = 32'h1;
      bus.fwd[0] = mk(5, 'hAA, 1'b0);
      bus.fwd[2] = mk(5, 'hBB, 1'b0);
      #1;
      chk("prio_res", 64'(bus.result[0]), 64'hAA);
      chk("prio_stall", 64'(bus.stall), 64'd0);

      // load-use on execute stalls, one stage older does not
      step(); idle();
      bus.ra[1]  = 7;
      bus.fwd[0] = mk(7, 'h70, 1'b1);
      #1;
      chk("lu_stall", 64'(bus.stall), 64'd1);
      step();
      bus.fwd[0] = mk(0, 0, 1'b0);
      bus.fwd[1] = mk(7, 'h77, 1'b1);
      #1;
      chk("lu_old_stall", 64'(bus.stall), 64'd0);
      chk("lu_old_res", 64'(bus.result[1]), 64'h77);

      // r0 never forwards
      step(); idle();
      bus.rd[0]  = 32'h1234;
      bus.fwd[0] = mk(0, 'hFF, 1'b0);
      #1;
      chk("r0_res", 64'(bus.result[0]), 64'h1234);
      chk("r0_stall", 64'(bus.stall), 64'd0);

      // two ports, mixed sources
      step(); idle();
      bus.ra[0]  = 3;
      bus.ra[1]  = 4;
      bus.fwd[0] = mk(4, 'h44, 1'b0);
      bus.fwd[1] = mk(3, 'h33, 1'b1);
      bus.fwd[2] = mk(3, 'h22, 1'b0);
      #1;
      chk("mix_res0", 64'(bus.result[0]), 64'h33);
      chk("mix_res1", 64'(bus.result[1]), 64'h44);

      // long op on r9 and its consumer
      step(); idle();
      issue(1'b1, 9);
      #1;
      chk("l9_iss", 64'(bus.stall), 64'd0);
      step(); idle();
      bus.ra[0] = 9;
      #1;
      chk("l9_pend", 64'(bus.pending[9]), 64'd1);
      chk("l9_stall", 64'(bus.stall), 64'd1);
      step();
      chk("l9_hold", 64'(bus.stall), 64'd1);
      bus.wb_long_valid = 1'b1;
      bus.wb_long_dst   = 9;
      bus.fwd[1]        = mk(9, 'h99, 1'b0);
      #1;
      chk("l9_wb_stall", 64'(bus.stall), 64'd0);
      chk("l9_wb_res", 64'(bus.result[0]), 64'h99);
      step(); idle();
      #1;
      chk("l9_clr", 64'(bus.pending), 64'd0);

      // structural limit
      step(); idle(); issue(1'b1, 3);
      step(); idle(); issue(1'b1, 4);
      #1;
      chk("s4_stall", 64'(bus.stall), 64'd0);
      step(); idle(); issue(1'b1, 5);
      #1;
      chk("s5_stall", 64'(bus.stall), 64'd1);
      chk("s_pend", 64'(bus.pending), 64'h18);
      step();
      chk("s5_hold", 64'(bus.stall), 64'd1);
      bus.wb_long_valid = 1'b1;
      bus.wb_long_dst   = 3;
      #1;
      chk("s5_wb", 64'(bus.stall), 64'd0);
      step(); idle(); issue(1'b1, 6);
      #1;
      chk("s_pend2", 64'(bus.pending), 64'h30);
      chk("s6_full", 64'(bus.stall), 64'd1);

      // write-after-write on a pending register
      step(); idle(); issue(1'b0, 4);
      #1;
      chk("waw", 64'(bus.stall), 64'd1);

      // stale writeback must not underflow
      step(); idle();
      bus.wb_long_valid = 1'b1;
      bus.wb_long_dst   = 10;
      step(); idle(); issue(1'b1, 6);
      #1;
      chk("stale_pend", 64'(bus.pending), 64'h30);
      chk("stale_full", 64'(bus.stall), 64'd1);

      // asynchronous reset mid-pending
      step(); idle();
      #1;
      reset = 1'b1;
      #1;
      chk("arst_pend", 64'(bus.pending), 64'd0);
      step();
      step();
      reset = 1'b0;
      issue(1'b1, 12);
      #1;
      chk("post_rst_stall", 64'(bus.stall), 64'd0);
      step(); idle();
      #1;
      chk("post_rst_pend", 64'(bus.pending), 64'h1000);

`ifdef FWD_STALL_CNT_EN
      step();
      reset = 1'b1;
      step();
      reset = 1'b0;
      chk("sc_zero", stall_cnt, 64'd0);
      bus.ra[0]  = 7;
      bus.fwd[0] = mk(7, 0, 1'b1);
      for (int n = 0; n < 10; n++) step();
      chk("sc_ten", stall_cnt, 64'd10);
      idle();
      reset = 1'b1;
      #1;
      chk("sc_rst", stall_cnt, 64'd0);
      step();
      reset = 1'b0;
`endif

      step(); idle();
      step();
      step();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
